input_vc_ctrl: RTL and testbench

Per-input-VC packet controller in the DART router, directly upstream of the VC allocator. It buffers incoming flits and requests an output VC when a head flit reaches the front of its queue. It binds the granted VC to the packet and streams the packet's flits toward the switch stage. It returns to idle after the tail flit departs.

---
 rtl/input_vc_ctrl_pkg.sv | 37 +++
 rtl/input_vc_ctrl_flit_fifo.sv | 75 +++++++
 rtl/input_vc_ctrl.sv | 142 ++++++++++++++
 tb/tb_input_vc_ctrl.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/input_vc_ctrl_pkg.sv
// Shared definitions for the input VC controller: width helper, flit field
// positions and the controller state encoding.
package input_vc_ctrl_pkg;

    // Number of bits needed to represent value (minimum 1).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int v = value; v > 0; v = v >> 1) begin
            result++;
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic int flit_head_bit(input int flit_width);
        return flit_width - 1;
    endfunction

    function automatic int flit_tail_bit(input int flit_width);
        return flit_width - 2;
    endfunction

    // MSB of the precomputed output-port field; the field extends downward.
    function automatic int flit_oport_msb(input int flit_width);
        return flit_width - 3;
    endfunction

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACTIVE = 2'd2
    } vc_state_e;

endpackage

// File: rtl/input_vc_ctrl_flit_fifo.sv
// Circular flit buffer with registered full/empty flags and an
// asynchronous front-entry read so the head flit is visible one cycle after push.
module flit_fifo
    import input_vc_ctrl_pkg::*;
#(
    parameter int WIDTH  = 36,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = clogb2(DEPTH - 1)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wr_data,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    logic [WIDTH-1:0]  mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr_reg;
    logic [ADDR_W-1:0] rd_ptr_reg;
    logic [ADDR_W:0]   count_reg;
    logic [ADDR_W:0]   count_next;
    logic              full_reg;
    logic              empty_reg;
    logic              push_ok;
    logic              pop_ok;

    assign push_ok = push & ~full_reg;
    assign pop_ok  = pop & ~empty_reg;

    always_comb begin
        count_next = count_reg;
        if (push_ok && !pop_ok) begin
            count_next = count_reg + 1'b1;
        end else if (pop_ok && !push_ok) begin
            count_next = count_reg - 1'b1;
        end
    end

    // DEPTH is a power of two, so the pointers wrap naturally.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
            full_reg   <= 1'b0;
            empty_reg  <= 1'b1;
        end else begin
            if (push_ok) begin
                wr_ptr_reg <= wr_ptr_reg + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr_reg <= rd_ptr_reg + 1'b1;
            end
            count_reg <= count_next;
            full_reg  <= (count_next == FULL_COUNT);
            empty_reg <= (count_next == '0);
        end
    end

    always_ff @(posedge clock) begin
        if (push_ok) begin
            mem[wr_ptr_reg] <= wr_data;
        end
    end

    assign rd_data = mem[rd_ptr_reg];
    assign full    = full_reg;
    assign empty   = empty_reg;

endmodule

// File: rtl/input_vc_ctrl.sv
// Per-input-VC packet controller: buffers flits, requests an output VC for
// each head flit, then streams the packet to the switch until its tail leaves.
module input_vc_ctrl
    import input_vc_ctrl_pkg::*;
#(
    parameter int NPORTS     = 5,
    parameter int NVCS       = 2,
    parameter int FLIT_WIDTH = 36,
    parameter int DEPTH      = 4,
    parameter int LOG_NPORTS = clogb2(NPORTS - 1),
    parameter int LOG_NVCS   = clogb2(NVCS - 1),
    parameter int LOG_DEPTH  = clogb2(DEPTH - 1)
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [FLIT_WIDTH-1:0] in_flit,
    input  logic                  in_valid,
    output logic                  in_ready,
    output logic [LOG_NPORTS-1:0] oport,
    output logic                  allocate,
    input  logic [LOG_NVCS-1:0]   next_vc,
    input  logic                  next_vc_valid,
    output logic [FLIT_WIDTH-1:0] out_flit,
    output logic [LOG_NVCS-1:0]   out_vc,
    output logic [LOG_NPORTS-1:0] out_oport,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  busy,
    output logic                  err
);

    localparam int HEAD_BIT  = flit_head_bit(FLIT_WIDTH);
    localparam int TAIL_BIT  = flit_tail_bit(FLIT_WIDTH);
    localparam int OPORT_MSB = flit_oport_msb(FLIT_WIDTH);

    vc_state_e             state_reg;
    vc_state_e             state_next;
    logic [LOG_NVCS-1:0]   out_vc_reg;
    logic [LOG_NVCS-1:0]   out_vc_next;
    logic [LOG_NPORTS-1:0] out_oport_reg;
    logic [LOG_NPORTS-1:0] out_oport_next;
    logic                  err_reg;
    logic                  err_next;

    logic [FLIT_WIDTH-1:0] front_flit;
    logic                  front_head;
    logic                  front_tail;
    logic [LOG_NPORTS-1:0] front_oport;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic                  push;
    logic                  pop;

    // fifo_full is a register, so in_ready only adds the global enable gate.
    assign in_ready = ~fifo_full & enable;
    assign push     = in_valid & in_ready;

    flit_fifo #(
        .WIDTH  (FLIT_WIDTH),
        .DEPTH  (DEPTH),
        .ADDR_W (LOG_DEPTH)
    ) u_flit_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .pop     (pop),
        .wr_data (in_flit),
        .rd_data (front_flit),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign front_head  = front_flit[HEAD_BIT];
    assign front_tail  = front_flit[TAIL_BIT];
    assign front_oport = front_flit[OPORT_MSB -: LOG_NPORTS];

    always_comb begin
        state_next     = state_reg;
        out_vc_next    = out_vc_reg;
        out_oport_next = out_oport_reg;
        err_next       = err_reg;
        allocate       = 1'b0;
        out_valid      = 1'b0;
        pop            = 1'b0;
        oport          = front_oport;

        case (state_reg)
            ST_IDLE, ST_WAIT: begin
                if (!fifo_empty) begin
                    if (front_head) begin
                        // The head stays queued; it leaves later as the first ACTIVE flit.
                        allocate = enable & next_vc_valid;
                        if (allocate) begin
                            state_next     = ST_ACTIVE;
                            out_vc_next    = next_vc;
                            out_oport_next = front_oport;
                        end else if (enable) begin
                            state_next = ST_WAIT;
                        end
                    end else if (state_reg == ST_IDLE) begin
                        pop = enable;
                        if (enable) begin
                            err_next = 1'b1;
                        end
                    end
                end
            end
            ST_ACTIVE: begin
                out_valid = enable & ~fifo_empty;
                pop       = out_valid & out_ready;
                if (pop && front_tail) begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            out_vc_reg    <= '0;
            out_oport_reg <= '0;
            err_reg       <= 1'b0;
        end else begin
            state_reg     <= state_next;
            out_vc_reg    <= out_vc_next;
            out_oport_reg <= out_oport_next;
            err_reg       <= err_next;
        end
    end

    assign out_flit  = front_flit;
    assign out_vc    = out_vc_reg;
    assign out_oport = out_oport_reg;
    assign busy      = (state_reg != ST_IDLE);
    assign err       = err_reg;

endmodule

// File: tb/tb_input_vc_ctrl.sv
// Directed bench for input_vc_ctrl: inputs change 1 ns after posedge,
// outputs are compared at the following negedge.
module tb_input_vc_ctrl;

    logic        clock;
    logic        reset;
    logic        enable;
    logic [35:0] in_flit;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  oport;
    logic        allocate;
    logic [0:0]  next_vc;
    logic        next_vc_valid;
    logic [35:0] out_flit;
    logic [0:0]  out_vc;
    logic [2:0]  out_oport;
    logic        out_valid;
    logic        out_ready;
    logic        busy;
    logic        err;

    int n_checks;
    int n_errors;

    input_vc_ctrl dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .in_flit       (in_flit),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .oport         (oport),
        .allocate      (allocate),
        .next_vc       (next_vc),
        .next_vc_valid (next_vc_valid),
        .out_flit      (out_flit),
        .out_vc        (out_vc),
        .out_oport     (out_oport),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .busy          (busy),
        .err           (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (!reset && enable && in_valid && in_ready)
            $display("[%0t] push flit %h", $time, in_flit);
        if (!reset && out_valid && out_ready)
            $display("[%0t] pop  flit %h vc %0d oport %0d", $time, out_flit, out_vc, out_oport);
        if (!reset && allocate)
            $display("[%0t] allocate vc %0d oport %0d", $time, next_vc, oport);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [35:0] mk(input logic h, input logic t, input logic [2:0] op,
                                       input logic [30:0] pl);
        return {h, t, op, pl};
    endfunction

    task automatic next_cycle;
        @(posedge clock);
        #1;
    endtask

    task automatic mid;
        @(negedge clock);
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        reset         = 1'b1;
        enable        = 1'b1;
        in_flit       = '0;
        in_valid      = 1'b0;
        next_vc       = '0;
        next_vc_valid = 1'b0;
        out_ready     = 1'b0;
        next_cycle();
        next_cycle();
        reset = 1'b0;

        // Reset state
        mid();
        check("rst_in_ready", in_ready, 1);
        check("rst_allocate", allocate, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_vc", out_vc, 0);
        check("rst_out_oport", out_oport, 0);
        check("rst_busy", busy, 0);
        check("rst_err", err, 0);

        // 3-flit packet, oport 2, granted VC 1
        next_cycle();
        in_valid = 1; in_flit = mk(1, 0, 3'd2, 31'd1);
        mid(); check("p1_alloc_early", allocate, 0);
        next_cycle();
        in_flit = mk(0, 0, 3'd0, 31'd2); next_vc_valid = 1; next_vc = 1;
        mid(); check("p1_alloc", allocate, 1); check("p1_oport", oport, 2);
        check("p1_no_outv", out_valid, 0);
        next_cycle();
        in_flit = mk(0, 1, 3'd0, 31'd3); out_ready = 1;
        mid(); check("p1_alloc_drop", allocate, 0); check("p1_out_vc", out_vc, 1);
        check("p1_out_oport", out_oport, 2); check("p1_f0", out_flit, mk(1, 0, 3'd2, 31'd1));
        check("p1_outv0", out_valid, 1);
        next_cycle();
        in_valid = 0;
        mid(); check("p1_f1", out_flit, mk(0, 0, 3'd0, 31'd2));
        next_cycle();
        mid(); check("p1_f2", out_flit, mk(0, 1, 3'd0, 31'd3)); check("p1_busy", busy, 1);
        next_cycle();
        next_vc_valid = 0; out_ready = 0;
        mid(); check("p1_idle", busy, 0); check("p1_outv_end", out_valid, 0);

        // Head waits 5 cycles for a VC offer
        next_cycle();
        in_valid = 1; in_flit = mk(1, 1, 3'd3, 31'd5);
        next_cycle();
        in_valid = 0;
        mid(); check("w_alloc1", allocate, 0);
        for (int i = 2; i <= 5; i++) begin
            next_cycle();
            mid();
            check($sformatf("w_busy%0d", i), busy, 1);
            check($sformatf("w_alloc%0d", i), allocate, 0);
            check($sformatf("w_outv%0d", i), out_valid, 0);
        end
        next_cycle();
        next_vc_valid = 1; next_vc = 0;
        mid(); check("w_alloc6", allocate, 1); check("w_oport", oport, 3);
        next_cycle();
        next_vc_valid = 0; out_ready = 1;
        mid(); check("w_outv", out_valid, 1); check("w_vc", out_vc, 0);
        check("w_out_oport", out_oport, 3); check("w_flit", out_flit, mk(1, 1, 3'd3, 31'd5));
        next_cycle();
        out_ready = 0;
        mid(); check("w_idle", busy, 0);

        // Fill the buffer, overflow attempt, then drain
        for (int i = 0; i < 4; i++) begin
            next_cycle();
            in_valid = 1;
            in_flit  = (i == 0) ? mk(1, 0, 3'd1, 31'd10) : mk(0, 0, 3'd0, 31'(10 + i));
        end
        next_cycle();
        in_flit = mk(0, 1, 3'd0, 31'd99); next_vc_valid = 1; next_vc = 1;
        mid(); check("f_full_ready", in_ready, 0); check("f_alloc", allocate, 1);
        check("f_oport", oport, 1);
        next_cycle();
        in_valid = 0; next_vc_valid = 0; out_ready = 1;
        mid(); check("f_still_full", in_ready, 0); check("f_h", out_flit, mk(1, 0, 3'd1, 31'd10));
        next_cycle();
        in_valid = 1; in_flit = mk(0, 1, 3'd0, 31'd14);
        mid(); check("f_ready_again", in_ready, 1); check("f_b11", out_flit, mk(0, 0, 3'd0, 31'd11));
        next_cycle();
        in_valid = 0;
        mid(); check("f_b12", out_flit, mk(0, 0, 3'd0, 31'd12));
        next_cycle();
        mid(); check("f_b13", out_flit, mk(0, 0, 3'd0, 31'd13));
        next_cycle();
        mid(); check("f_t14", out_flit, mk(0, 1, 3'd0, 31'd14)); check("f_outv", out_valid, 1);
        next_cycle();
        mid(); check("f_idle", busy, 0); check("f_empty", out_valid, 0);

        // Ten 2-flit packets through the wrapping buffer
        for (int k = 0; k < 10; k++) begin
            next_cycle();
            in_valid = 1; in_flit = mk(1, 0, 3'(k % 5), 31'(100 + k));
            out_ready = 0; next_vc_valid = 0;
            next_cycle();
            in_flit = mk(0, 1, 3'd0, 31'(200 + k)); next_vc_valid = 1; next_vc = 1'(k % 2);
            mid(); check($sformatf("pk%0d_alloc", k), allocate, 1);
            check($sformatf("pk%0d_oport", k), oport, k % 5);
            next_cycle();
            in_valid = 0; next_vc_valid = 0; out_ready = 1;
            mid(); check($sformatf("pk%0d_head", k), out_flit, mk(1, 0, 3'(k % 5), 31'(100 + k)));
            check($sformatf("pk%0d_vc", k), out_vc, k % 2);
            next_cycle();
            mid(); check($sformatf("pk%0d_tail", k), out_flit, mk(0, 1, 3'd0, 31'(200 + k)));
            next_cycle();
            out_ready = 0;
            mid(); check($sformatf("pk%0d_idle", k), busy, 0);
        end

        // Single-flit packet followed immediately by another head
        next_cycle();
        in_valid = 1; in_flit = mk(1, 1, 3'd4, 31'd21);
        next_cycle();
        in_flit = mk(1, 1, 3'd1, 31'd22); next_vc_valid = 1; next_vc = 1;
        mid(); check("s_alloc1", allocate, 1); check("s_oport1", oport, 4);
        next_cycle();
        in_valid = 0; out_ready = 1; next_vc = 0;
        mid(); check("s_no_alloc", allocate, 0); check("s_flit1", out_flit, mk(1, 1, 3'd4, 31'd21));
        check("s_vc1", out_vc, 1);
        next_cycle();
        mid(); check("s_alloc2", allocate, 1); check("s_oport2", oport, 1);
        check("s_no_outv", out_valid, 0);
        next_cycle();
        next_vc_valid = 0;
        mid(); check("s_flit2", out_flit, mk(1, 1, 3'd1, 31'd22)); check("s_vc2", out_vc, 0);
        check("s_oport_b", out_oport, 1);
        next_cycle();
        out_ready = 0;
        mid(); check("s_idle", busy, 0);

        // Stray body flit in IDLE
        next_cycle();
        in_valid = 1; in_flit = mk(0, 0, 3'd0, 31'd30);
        mid(); check("e_err_before", err, 0);
        next_cycle();
        in_valid = 0;
        mid(); check("e_err_pending", err, 0); check("e_busy", busy, 0);
        next_cycle();
        in_valid = 1; in_flit = mk(1, 1, 3'd2, 31'd31);
        mid(); check("e_err_set", err, 1); check("e_discarded", out_valid, 0);
        next_cycle();
        in_valid = 0; next_vc_valid = 1; next_vc = 1;
        mid(); check("e_alloc", allocate, 1);
        next_cycle();
        next_vc_valid = 0; out_ready = 1;
        mid(); check("e_flit", out_flit, mk(1, 1, 3'd2, 31'd31)); check("e_err_sticky", err, 1);
        next_cycle();
        out_ready = 0;

        // enable low mid-packet, then reset mid-packet
        next_cycle();
        in_valid = 1; in_flit = mk(1, 0, 3'd3, 31'd40);
        next_cycle();
        in_flit = mk(0, 0, 3'd0, 31'd41); next_vc_valid = 1; next_vc = 1;
        next_cycle();
        in_flit = mk(0, 1, 3'd0, 31'd42); next_vc_valid = 0; out_ready = 1;
        mid(); check("g_head", out_flit, mk(1, 0, 3'd3, 31'd40));
        next_cycle();
        enable = 0; in_valid = 1; in_flit = mk(0, 1, 3'd0, 31'd77);
        for (int i = 0; i < 3; i++) begin
            mid();
            check($sformatf("g_outv%0d", i), out_valid, 0);
            check($sformatf("g_inrdy%0d", i), in_ready, 0);
            check($sformatf("g_busy%0d", i), busy, 1);
            next_cycle();
        end
        enable = 1; in_valid = 0;
        mid(); check("g_resume", out_flit, mk(0, 0, 3'd0, 31'd41)); check("g_outv", out_valid, 1);
        next_cycle();
        out_ready = 0; reset = 1;
        mid(); check("g_pre_rst_vc", out_vc, 1);
        next_cycle();
        mid();
        check("r_busy", busy, 0); check("r_outv", out_valid, 0); check("r_vc", out_vc, 0);
        check("r_oport", out_oport, 0); check("r_err", err, 0); check("r_inrdy", in_ready, 1);
        check("r_alloc", allocate, 0);
        next_cycle();
        reset = 0; out_ready = 1;
        mid(); check("r_flushed", out_valid, 0); check("r_idle", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
